// File: rtl/stage2_conv_scheduler.sv
// rtl/stage2_conv_scheduler.sv - stage-2 convolution sequencer: window issue, channel accumulate, bias/ReLU, output handshake
//
// Walks every output position in raster order. For each position it issues one
// window per input channel to the 5x5 MAC kernel, sums the returned per-channel
// results, adds the frame bias, optionally clamps negatives to zero, and holds
// the finished pixel on a valid/ready port until it is accepted.
//
// Optional feature macro: STAGE2_SCHED_RELU_EN
//   defined   : a negative (acc + bias) is output as 0
//   undefined : the signed sum is output unmodified
//
// Ports:
//   clk, reset_n          clock, asynchronous active-low reset
//   i_start               start-frame pulse, honoured only in IDLE
//   i_abort               synchronous abort, highest priority
//   i_bias                signed frame bias, sampled with i_start
//   o_busy                high in every state except IDLE
//   o_done                one-cycle pulse after the last pixel handshake
//   o_kern_valid          kernel input valid (one cycle per channel window)
//   o_win_x/y/ch          window position and channel for the buffers
//   i_kern_valid/acc      kernel result strobe and signed result
//   o_ot_valid/i_ot_ready output pixel handshake
//   o_ot_data/x/y         signed output pixel and its coordinates
//   o_err                 sticky: kernel result arrived when none was expected

module stage2_conv_scheduler #(
    parameter  int IN_CH  = 3,
    parameter  int OUT_W  = 8,
    parameter  int OUT_H  = 8,
    parameter  int KLAT   = 2,
    parameter  int AK_BW  = 32,
    parameter  int ACC_BW = 36,
    localparam int XW     = (OUT_W > 1) ? $clog2(OUT_W) : 1,
    localparam int YW     = (OUT_H > 1) ? $clog2(OUT_H) : 1,
    localparam int CW     = (IN_CH > 1) ? $clog2(IN_CH) : 1,
    localparam int NW     = $clog2(IN_CH + 1)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              i_start,
    input  logic              i_abort,
    input  logic [AK_BW-1:0]  i_bias,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_kern_valid,
    output logic [XW-1:0]     o_win_x,
    output logic [YW-1:0]     o_win_y,
    output logic [CW-1:0]     o_win_ch,
    input  logic              i_kern_valid,
    input  logic [AK_BW-1:0]  i_kern_acc,
    output logic              o_ot_valid,
    input  logic              i_ot_ready,
    output logic [ACC_BW-1:0] o_ot_data,
    output logic [XW-1:0]     o_ot_x,
    output logic [YW-1:0]     o_ot_y,
    output logic              o_err
);

    // Elaboration-time parameter sanity: the accumulator must hold IN_CH
    // kernel results plus the bias without overflow.
    generate
        if (IN_CH < 1 || OUT_W < 1 || OUT_H < 1 || KLAT < 1 ||
            ACC_BW < AK_BW + $clog2(IN_CH) + 1) begin : g_bad_params
            $error("stage2_conv_scheduler: illegal parameter combination");
        end
    endgenerate

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ISSUE = 3'd1;
    localparam logic [2:0] S_DRAIN = 3'd2;
    localparam logic [2:0] S_OUT   = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    localparam logic [XW-1:0] X_LAST  = XW'(OUT_W - 1);
    localparam logic [YW-1:0] Y_LAST  = YW'(OUT_H - 1);
    localparam logic [CW-1:0] CH_LAST = CW'(IN_CH - 1);
    localparam logic [NW-1:0] N_FULL  = NW'(IN_CH);
    localparam logic [NW-1:0] N_LAST  = NW'(IN_CH - 1);

    logic [2:0]               r_state;
    logic [2:0]               w_state_nxt;
    logic [XW-1:0]            r_x;
    logic [YW-1:0]            r_y;
    logic [CW-1:0]            r_ch;
    logic [NW-1:0]            r_cnt;
    logic signed [ACC_BW-1:0] r_acc;
    logic signed [AK_BW-1:0]  r_bias;
    logic signed [ACC_BW-1:0] r_ot_data;
    logic                     r_err;

    logic signed [ACC_BW-1:0] w_kern_ext;
    logic signed [ACC_BW-1:0] w_bias_ext;
    logic signed [ACC_BW-1:0] w_acc_nxt;
    logic signed [ACC_BW-1:0] w_sum;
    logic signed [ACC_BW-1:0] w_pix;
    logic                     w_collect;
    logic                     w_last_res;
    logic                     w_unexpected;
    logic                     w_handshake;
    logic                     w_last_pos;

    assign w_kern_ext = {{(ACC_BW - AK_BW){i_kern_acc[AK_BW-1]}}, i_kern_acc};
    assign w_bias_ext = {{(ACC_BW - AK_BW){r_bias[AK_BW-1]}}, r_bias};

    // A result is only accepted while windows are outstanding for the
    // current position; anything else is flagged and dropped.
    assign w_collect    = i_kern_valid && (r_state == S_ISSUE || r_state == S_DRAIN)
                          && (r_cnt != N_FULL);
    assign w_unexpected = i_kern_valid && !w_collect;
    assign w_last_res   = w_collect && (r_cnt == N_LAST);

    // The final channel's result is folded in on the same edge that enters
    // OUT, so the pixel is formed from the not-yet-registered accumulator.
    assign w_acc_nxt = r_acc + w_kern_ext;
    assign w_sum     = w_acc_nxt + w_bias_ext;

`ifdef STAGE2_SCHED_RELU_EN
    assign w_pix = w_sum[ACC_BW-1] ? '0 : w_sum;
`else
    assign w_pix = w_sum;
`endif

    assign w_handshake = (r_state == S_OUT) && i_ot_ready;
    assign w_last_pos  = (r_x == X_LAST) && (r_y == Y_LAST);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: begin
                // Results trail issues by at least one cycle, so the last
                // result normally lands in DRAIN; handled here for safety.
                if (w_last_res) begin
                    w_state_nxt = S_OUT;
                end else if (r_ch == CH_LAST) begin
                    w_state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (w_last_res) begin
                    w_state_nxt = S_OUT;
                end
            end
            S_OUT: begin
                if (i_ot_ready) begin
                    w_state_nxt = w_last_pos ? S_DONE : S_ISSUE;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
        if (i_abort) begin
            w_state_nxt = S_IDLE;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= S_IDLE;
            r_x       <= '0;
            r_y       <= '0;
            r_ch      <= '0;
            r_cnt     <= '0;
            r_acc     <= '0;
            r_bias    <= '0;
            r_ot_data <= '0;
            r_err     <= 1'b0;
        end else begin
            r_state <= w_state_nxt;

            // Sticky until reset; abort and restart leave it alone.
            if (w_unexpected) begin
                r_err <= 1'b1;
            end

            if (i_abort) begin
                r_x   <= '0;
                r_y   <= '0;
                r_ch  <= '0;
                r_cnt <= '0;
                r_acc <= '0;
            end else begin
                if (w_collect) begin
                    r_acc <= w_acc_nxt;
                    r_cnt <= r_cnt + NW'(1);
                    if (w_last_res) begin
                        r_ot_data <= w_pix;
                    end
                end

                case (r_state)
                    S_IDLE: begin
                        if (i_start) begin
                            r_bias <= i_bias;
                            r_x    <= '0;
                            r_y    <= '0;
                            r_ch   <= '0;
                            r_cnt  <= '0;
                            r_acc  <= '0;
                        end
                    end
                    S_ISSUE: begin
                        // ch parks on the last channel through DRAIN and
                        // OUT; it is rewound on the output handshake.
                        if (r_ch != CH_LAST) begin
                            r_ch <= r_ch + CW'(1);
                        end
                    end
                    S_OUT: begin
                        if (w_handshake) begin
                            r_acc <= '0;
                            r_cnt <= '0;
                            r_ch  <= '0;
                            if (!w_last_pos) begin
                                if (r_x == X_LAST) begin
                                    r_x <= '0;
                                    r_y <= r_y + YW'(1);
                                end else begin
                                    r_x <= r_x + XW'(1);
                                end
                            end
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    // Status and strobes decode directly from state so they reset to 0 and
    // drop the cycle after an abort.
    assign o_busy       = (r_state != S_IDLE);
    assign o_done       = (r_state == S_DONE);
    assign o_kern_valid = (r_state == S_ISSUE);
    assign o_ot_valid   = (r_state == S_OUT);
    assign o_win_x      = r_x;
    assign o_win_y      = r_y;
    assign o_win_ch     = r_ch;
    // Position does not move while in OUT, so it doubles as the pixel tag.
    assign o_ot_x       = r_x;
    assign o_ot_y       = r_y;
    assign o_ot_data    = r_ot_data;
    assign o_err        = r_err;

endmodule

// File: tb/tb_stage2_conv_scheduler.sv
// tb/tb_stage2_conv_scheduler.sv - scoreboard bench for stage2_conv_scheduler
module tb_stage2_conv_scheduler;

    localparam int IN_CH  = 3;
    localparam int OUT_W  = 2;
    localparam int OUT_H  = 2;
    localparam int KLAT   = 2;
    localparam int AK_BW  = 32;
    localparam int ACC_BW = 36;
    localparam int XW     = (OUT_W > 1) ? $clog2(OUT_W) : 1;
    localparam int YW     = (OUT_H > 1) ? $clog2(OUT_H) : 1;
    localparam int CW     = (IN_CH > 1) ? $clog2(IN_CH) : 1;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              i_start;
    logic              i_abort;
    logic [AK_BW-1:0]  i_bias;
    logic              o_busy;
    logic              o_done;
    logic              o_kern_valid;
    logic [XW-1:0]     o_win_x;
    logic [YW-1:0]     o_win_y;
    logic [CW-1:0]     o_win_ch;
    logic              i_kern_valid;
    logic [AK_BW-1:0]  i_kern_acc;
    logic              o_ot_valid;
    logic              i_ot_ready;
    logic [ACC_BW-1:0] o_ot_data;
    logic [XW-1:0]     o_ot_x;
    logic [YW-1:0]     o_ot_y;
    logic              o_err;

    always #5 clk = ~clk;

    stage2_conv_scheduler #(
        .IN_CH(IN_CH), .OUT_W(OUT_W), .OUT_H(OUT_H),
        .KLAT(KLAT), .AK_BW(AK_BW), .ACC_BW(ACC_BW)
    ) dut (
        .clk(clk), .reset_n(reset_n), .i_start(i_start), .i_abort(i_abort),
        .i_bias(i_bias), .o_busy(o_busy), .o_done(o_done),
        .o_kern_valid(o_kern_valid), .o_win_x(o_win_x), .o_win_y(o_win_y),
        .o_win_ch(o_win_ch), .i_kern_valid(i_kern_valid), .i_kern_acc(i_kern_acc),
        .o_ot_valid(o_ot_valid), .i_ot_ready(i_ot_ready), .o_ot_data(o_ot_data),
        .o_ot_x(o_ot_x), .o_ot_y(o_ot_y), .o_err(o_err)
    );

    typedef struct { int x; int y; longint d; } exp_t;
    typedef struct { longint due; longint v; } kres_t;

    longint kv [OUT_H][OUT_W][IN_CH];
    exp_t   exp_q[$];
    kres_t  kq[$];

    int     tests = 0;
    int     fails = 0;
    int     abort_seq = 0;
    int     inj_seq = 0;
    int     hs_total = 0;
    int     frame_cnt = 0;

    task automatic chk(input string name, input longint got, input longint exp);
        tests++;
        if (got != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    // Kernel model: every issued window returns its table value KLAT cycles later.
    longint cyc = 0;
    int     k_abort_seen = 0;
    int     k_inj_seen = 0;
    always begin
        kres_t r;
        @(posedge clk);
        #1;
        cyc++;
        if (abort_seq != k_abort_seen) begin
            kq.delete();
            k_abort_seen = abort_seq;
        end
        if (kq.size() > 0 && kq[0].due == cyc) begin
            r = kq.pop_front();
            i_kern_valid = 1'b1;
            i_kern_acc   = AK_BW'(r.v);
        end else if (inj_seq != k_inj_seen) begin
            k_inj_seen   = inj_seq;
            i_kern_valid = 1'b1;
            i_kern_acc   = 32'h1234_5678;
        end else begin
            i_kern_valid = 1'b0;
            i_kern_acc   = $urandom;
        end
        if (reset_n && o_kern_valid) begin
            r.due = cyc + KLAT;
            if (int'(o_win_ch) < IN_CH)
                r.v = kv[o_win_y][o_win_x][o_win_ch];
            else
                r.v = 0;
            kq.push_back(r);
        end
    end

    // Monitor: pops the scoreboard on each output handshake and checks issue order.
    int     issue_ch = 0;
    bit     stall = 0, done_exp = 0, busy_exp = 0, next_exp = 0;
    longint held_d;
    int     held_x, held_y;
    int     m_abort_seen = 0;
    always @(negedge clk) begin
        exp_t e;
        if (!reset_n) begin
            issue_ch = 0; stall = 0; done_exp = 0; busy_exp = 0; next_exp = 0;
        end else begin
            if (abort_seq != m_abort_seen) begin
                issue_ch = 0; stall = 0; done_exp = 0; busy_exp = 0; next_exp = 0;
                m_abort_seen = abort_seq;
            end
            if (o_ot_valid)
                chk("no_issue_in_out", o_kern_valid, 0);
            if (next_exp) begin
                chk("issue_after_hs", o_kern_valid, 1);
                chk("ch_after_hs", o_win_ch, 0);
                next_exp = 0;
            end
            if (busy_exp) begin
                chk("busy_after_done", o_busy, 0);
                busy_exp = 0;
            end
            if (done_exp || o_done) begin
                chk("done_pulse", o_done, done_exp);
                if (done_exp) busy_exp = 1;
                if (o_done) frame_cnt++;
                done_exp = 0;
            end
            if (o_kern_valid) begin
                chk("win_ch", o_win_ch, issue_ch);
                chk("issue_has_pixel", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) begin
                    chk("win_x", o_win_x, exp_q[0].x);
                    chk("win_y", o_win_y, exp_q[0].y);
                end
                issue_ch++;
            end
            if (o_ot_valid) begin
                if (stall) begin
                    chk("hold_data", longint'($signed(o_ot_data)), held_d);
                    chk("hold_x", o_ot_x, held_x);
                    chk("hold_y", o_ot_y, held_y);
                end
                if (i_ot_ready) begin
                    chk("pixel_expected", exp_q.size() > 0, 1);
                    if (exp_q.size() > 0) begin
                        e = exp_q.pop_front();
                        chk("ot_data", longint'($signed(o_ot_data)), e.d);
                        chk("ot_x", o_ot_x, e.x);
                        chk("ot_y", o_ot_y, e.y);
                        chk("issues_per_pixel", issue_ch, IN_CH);
                        if (e.x == OUT_W - 1 && e.y == OUT_H - 1) done_exp = 1;
                        else next_exp = 1;
                    end
                    issue_ch = 0;
                    hs_total++;
                    stall = 0;
                end else begin
                    stall  = 1;
                    held_d = longint'($signed(o_ot_data));
                    held_x = o_ot_x;
                    held_y = o_ot_y;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: pixel = bias + sum of its channel results, clamped if ReLU is built in.
    task automatic prep(input int vmode, input longint bias);
        exp_t e;
        int   r;
        for (int y = 0; y < OUT_H; y++) begin
            for (int x = 0; x < OUT_W; x++) begin
                e.x = x; e.y = y; e.d = bias;
                for (int c = 0; c < IN_CH; c++) begin
                    if (vmode == 1)      kv[y][x][c] = (c + 1) * 10;
                    else if (vmode == 2) kv[y][x][c] = (c == 0) ? -100 : 0;
                    else begin r = $urandom; kv[y][x][c] = r; end
                    e.d += kv[y][x][c];
                end
`ifdef STAGE2_SCHED_RELU_EN
                if (e.d < 0) e.d = 0;
`endif
                exp_q.push_back(e);
            end
        end
    endtask

    // rmode: 0 random ready + start-while-busy, 1 ready high, 2 ten-cycle stall on
    // first pixel, 3 stall with a stray kernel result injected.
    task automatic run_frame(input int vmode, input int rmode);
        longint bias;
        int     rb, base_frames, base_hs, stall_n;
        bit     seen_valid, poked;
        rb = $urandom;
        bias = (vmode == 0) ? longint'(rb) : 5;
        prep(vmode, bias);
        base_frames = frame_cnt;
        base_hs = hs_total;
        stall_n = 0; seen_valid = 0; poked = 0;
        i_bias = AK_BW'(bias);
        i_start = 1'b1;
        i_ot_ready = 1'b1;
        for (int k = 1; k <= 3000 && frame_cnt == base_frames; k++) begin
            tick();
            i_start = 1'b0;
            i_bias = $urandom;
            if (rmode == 1 && !seen_valid && o_ot_valid) begin
                chk("first_out_latency", k, IN_CH + KLAT + 1);
                seen_valid = 1;
            end
            case (rmode)
                0: begin
                    i_ot_ready = 1'($urandom_range(0, 1));
                    if (!poked && o_kern_valid) begin
                        i_start = 1'b1;
                        poked = 1;
                    end
                end
                2, 3: begin
                    if (o_ot_valid && hs_total == base_hs &&
                        stall_n < ((rmode == 2) ? 10 : 5)) begin
                        i_ot_ready = 1'b0;
                        if (rmode == 3 && stall_n == 1) inj_seq++;
                        stall_n++;
                    end else begin
                        i_ot_ready = 1'b1;
                    end
                end
                default: i_ot_ready = 1'b1;
            endcase
        end
        chk("frame_completed", frame_cnt - base_frames, 1);
        i_ot_ready = 1'b1;
    endtask

    task automatic wait_drain(input int pix, output bit found);
        found = 0;
        for (int k = 0; k < 200 && !found; k++) begin
            tick();
            i_start = 1'b0;
            if (hs_total == pix && o_busy && !o_kern_valid && !o_ot_valid) found = 1;
        end
        chk("reached_drain", found, 1);
    endtask

    initial begin
        bit found;
        int base_hs;
        reset_n = 1'b0; i_start = 1'b0; i_abort = 1'b0; i_bias = '0;
        i_ot_ready = 1'b1; i_kern_valid = 1'b0; i_kern_acc = '0;
        repeat (3) tick();
        chk("rst_busy", o_busy, 0);
        chk("rst_done", o_done, 0);
        chk("rst_kern_valid", o_kern_valid, 0);
        chk("rst_ot_valid", o_ot_valid, 0);
        chk("rst_err", o_err, 0);
        chk("rst_ot_data", o_ot_data, 0);
        chk("rst_win_ch", o_win_ch, 0);
        reset_n = 1'b1;
        tick();

        run_frame(1, 1);
        chk("err_clear_basic", o_err, 0);
        run_frame(2, 1);
        run_frame(1, 2);
        for (int i = 0; i < 6; i++) run_frame(0, 0);
        chk("err_clear_random", o_err, 0);

        // Abort during DRAIN of the second pixel, then a fresh frame.
        base_hs = hs_total;
        prep(1, 5);
        i_bias = 32'd5; i_start = 1'b1;
        wait_drain(base_hs + 1, found);
        i_abort = 1'b1;
        abort_seq++;
        tick();
        i_abort = 1'b0;
        chk("abort_busy", o_busy, 0);
        chk("abort_ot_valid", o_ot_valid, 0);
        chk("abort_kern_valid", o_kern_valid, 0);
        exp_q.delete();
        tick();
        run_frame(0, 1);
        chk("err_clear_abort", o_err, 0);

        // Start and abort together: stays idle.
        i_start = 1'b1; i_abort = 1'b1;
        tick();
        i_start = 1'b0; i_abort = 1'b0;
        chk("start_abort_idle", o_busy, 0);
        tick();

        run_frame(0, 3);
        chk("err_set", o_err, 1);
        run_frame(0, 1);
        chk("err_sticky", o_err, 1);

        // Asynchronous reset mid-DRAIN.
        base_hs = hs_total;
        prep(1, 5);
        i_bias = 32'd5; i_start = 1'b1;
        wait_drain(base_hs, found);
        #2;
        reset_n = 1'b0;
        abort_seq++;
        #1;
        chk("mrst_busy", o_busy, 0);
        chk("mrst_kern_valid", o_kern_valid, 0);
        chk("mrst_ot_valid", o_ot_valid, 0);
        chk("mrst_done", o_done, 0);
        chk("mrst_err", o_err, 0);
        chk("mrst_ot_data", o_ot_data, 0);
        chk("mrst_win_ch", o_win_ch, 0);
        exp_q.delete();
        repeat (2) tick();
        reset_n = 1'b1;
        tick();
        run_frame(1, 1);
        chk("err_after_reset", o_err, 0);

        repeat (3) tick();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/stage2_conv_scheduler.md
# stage2_conv_scheduler

Sequencer for the stage-2 convolution kernel. On a start pulse it walks every output position in raster order and, for each position, issues one window per input channel to the 5x5 multiply-accumulate kernel. It sums the per-channel kernel results, adds a per-output bias, optionally applies ReLU, and presents the finished pixel on a valid/ready output port. It sits between the stage-2 window/weight buffers, which are addressed by its position/channel outputs, and the stage-2 pooling/output logic.

## Interface
- IN_CH, 3: input channels accumulated per output pixel (≥1)
- OUT_W, 8: output positions per row (≥1)
- OUT_H, 8: output rows (≥1)
- KLAT, 2: kernel latency, from valid-in to valid-out, in cycles (≥1)
- AK_BW, 32: kernel result width (signed)
- ACC_BW, 36: accumulator and output width (signed, ≥ AK_BW + clog2(IN_CH) + 1)

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous, active-low reset
- i_start  in  1  start-frame pulse; ignored unless IDLE
- i_abort  in  1  synchronous abort; highest priority
- i_bias  in  AK_BW  signed bias for the current frame; sampled at start
- o_busy  out  1  high in any state except IDLE
- o_done  out  1  one-cycle pulse after the last pixel handshake
- o_kern_valid  out  1  drives the kernel's input valid
- o_win_x  out  clog2(OUT_W)  window column for buffer addressing
- o_win_y  out  clog2(OUT_H)  window row
- o_win_ch  out  clog2(IN_CH) (min 1)  channel select for the fmap/weight buffers
- i_kern_valid  in  1  kernel output valid
- i_kern_acc  in  AK_BW  signed kernel result
- o_ot_valid  out  1  output pixel valid
- i_ot_ready  in  1  downstream accept
- o_ot_data  out  ACC_BW  signed output pixel
- o_ot_x / o_ot_y  out  as o_win_x/o_win_y  coordinates of o_ot_data
- o_err  out  1  sticky; set by an unexpected i_kern_valid

## Operation
- FSM states: IDLE, ISSUE, DRAIN, OUT, DONE.
- **IDLE**
  - i_start: latch i_bias; clear x, y, ch, the accumulator and the receive counter; go to ISSUE.
- **ISSUE**
  - o_kern_valid = 1 every cycle.
  - o_win_ch counts 0..IN_CH-1.
  - o_win_x/o_win_y hold the current position.
  - After ch = IN_CH-1 is issued, go to DRAIN.
- **Result collection** (ISSUE and DRAIN)
  - Each i_kern_valid adds sign-extended i_kern_acc to the accumulator and increments the receive counter.
  - When the counter reaches IN_CH, go to OUT.
- **OUT**
  - o_ot_data = acc + sign-extended bias, after optional ReLU. It is registered on entry to OUT.
  - o_ot_valid is held with stable data and coordinates until i_ot_ready.
  - On handshake, clear acc, counter and ch.
  - If the position was the last (x = OUT_W-1, y = OUT_H-1), go to DONE. Otherwise advance x; x wraps to 0 and increments y. Then go to ISSUE.
- **DONE**: o_done = 1 for one cycle, then IDLE.
- i_kern_valid in IDLE, OUT or DONE, or when the counter is already IN_CH: the result is ignored and o_err is set. o_err is cleared only by reset.
- i_abort, in any state: next state is IDLE. o_kern_valid, o_ot_valid and o_done drop next cycle; counters and accumulator clear. o_err is unaffected.
- i_start and i_abort in the same cycle: abort wins, and the state stays IDLE.
- No wrap or saturation. ACC_BW is sized so the sum cannot overflow.

## Timing
- All outputs reset to 0, and the state resets to IDLE.
- i_start in cycle 0: o_kern_valid is high in cycles 1..IN_CH.
- Results arrive in cycles 1+KLAT..IN_CH+KLAT.
- o_ot_valid is first high in cycle IN_CH+KLAT+1.
- Per pixel, with i_ot_ready tied high: IN_CH+KLAT+1 cycles. The next ISSUE starts the cycle after the handshake.
- The kernel has no stall input. Backpressure is absorbed in OUT only, and no windows are in flight while in OUT.
- o_done is asserted the cycle after the final handshake. o_busy deasserts one cycle later.

## Configuration
- STAGE2_SCHED_RELU_EN defined: a negative acc + bias outputs 0.
- STAGE2_SCHED_RELU_EN undefined: the signed sum is output unmodified.

## Test plan
Unless stated otherwise, tests use IN_CH=3, OUT_W=2, OUT_H=2, KLAT=2.

- **Basic frame**: bias=5; a kernel model returns 10, 20, 30 per pixel; i_ot_ready=1.
  - Four outputs of 65, at (0,0), (1,0), (0,1), (1,1).
  - o_kern_valid is high 3 cycles per pixel, with ch 0,1,2.
  - o_done one cycle after the 4th output.
- **ReLU**: results -100, 0, 0, bias=5.
  - With the macro: 0.
  - Without the macro: -95.
- **Backpressure**: i_ot_ready low for 10 cycles on pixel 1.
  - o_ot_valid, data and coordinates stay stable.
  - o_kern_valid stays 0 throughout.
  - Pixel 2 ISSUE begins the cycle after ready rises.
- **Abort**: i_abort during DRAIN of pixel 2.
  - Next cycle is IDLE, with o_busy=0 and no o_ot_valid.
  - A new i_start yields a correct full frame starting at (0,0).
- **Error**: an extra i_kern_valid in OUT.
  - o_err=1 and stays set.
  - o_ot_data is unchanged.
  - A restart clears neither the flag nor anything else except via reset.
- **Start while busy / reset mid-frame**: i_start during ISSUE is ignored. Asserting reset_n=0 mid-DRAIN clears all outputs immediately.
